fetch_ctrl: RTL and testbench

Parametrised instruction-fetch controller: the next-generation PC sequencer for the 9-bit-instruction processor. It holds the PC register and a run-time-loadable branch-target table. The table is organised as selectable banks and replaces the fixed-constant relative/absolute LUT pairs. It adds a call/return address stack, so function calls land on real targets instead of a hard-coded address. It sits between the controller (branch/call/ret strobes, latched ALU zero flag) and InstROM (consumes `pc`).

---
 rtl/fetch_ctrl.sv | 108 ++++++++++
 tb/tb_fetch_ctrl.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_ctrl.sv
// rtl/fetch_ctrl.sv - PC sequencer with banked branch-target table and circular return stack
module fetch_ctrl #(
    parameter int PC_W      = 16,
    parameter int LUT_DEPTH = 16,
    parameter int LUT_BANKS = 2,
    parameter int RAS_DEPTH = 4,
    parameter int SEL_W     = $clog2(LUT_BANKS),
    parameter int IDX_W     = $clog2(LUT_DEPTH) + SEL_W,
    parameter int CNT_W     = $clog2(RAS_DEPTH + 1)
) (
    input  logic             CLK,
    input  logic             reset,
    input  logic             start,
    input  logic             br_abs,
    input  logic             br_rel_z,
    input  logic             br_rel_nz,
    input  logic             call,
    input  logic             ret,
    input  logic             flag_zero,
    input  logic [IDX_W-1:0] target_idx,
    input  logic             halt,
    input  logic             tbl_we,
    input  logic [IDX_W-1:0] tbl_waddr,
    input  logic [PC_W-1:0]  tbl_wdata,
    output logic [PC_W-1:0]  pc,
    output logic             done,
    output logic [CNT_W-1:0] ras_count,
    output logic             ras_overflow,
    output logic             ras_underflow
);

    localparam int N_ENT = LUT_DEPTH * LUT_BANKS;
    localparam int PTR_W = $clog2(RAS_DEPTH);

    logic [PC_W-1:0]  tbl     [N_ENT];
    logic [PC_W-1:0]  ras_mem [RAS_DEPTH];
    logic [PTR_W-1:0] ras_ptr;
    logic [PTR_W-1:0] top_ptr;
    logic [PC_W-1:0]  entry;
    logic [PC_W-1:0]  pc_inc;
    logic             ras_full;
    logic             ras_empty;
    logic             rel_taken;

    // The packed {entry, bank} index is used directly as the flat table address.
    assign entry     = tbl[target_idx];
    assign pc_inc    = pc + PC_W'(1);
    assign top_ptr   = ras_ptr - PTR_W'(1);
    assign ras_full  = (ras_count == CNT_W'(RAS_DEPTH));
    assign ras_empty = (ras_count == '0);
    assign rel_taken = (br_rel_z && flag_zero) || (br_rel_nz && !flag_zero);

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < N_ENT; i++) tbl[i] <= '0;
        end else if (tbl_we) begin
            tbl[tbl_waddr] <= tbl_wdata;
        end
    end

    // ras_ptr names the next free slot; when full it also names the oldest entry,
    // so a push on a full stack overwrites exactly that one.
    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            pc            <= '0;
            done          <= 1'b0;
            ras_count     <= '0;
            ras_ptr       <= '0;
            ras_overflow  <= 1'b0;
            ras_underflow <= 1'b0;
            for (int i = 0; i < RAS_DEPTH; i++) ras_mem[i] <= '0;
        end else if (start) begin
            pc            <= '0;
            done          <= 1'b0;
            ras_count     <= '0;
            ras_ptr       <= '0;
            ras_overflow  <= 1'b0;
            ras_underflow <= 1'b0;
            for (int i = 0; i < RAS_DEPTH; i++) ras_mem[i] <= '0;
        end else if (done) begin
            pc <= pc;
        end else if (halt) begin
            done <= 1'b1;
        end else if (ret) begin
            if (ras_empty) begin
                pc            <= pc_inc;
                ras_underflow <= 1'b1;
            end else begin
                pc        <= ras_mem[top_ptr];
                ras_ptr   <= top_ptr;
                ras_count <= ras_count - CNT_W'(1);
            end
        end else if (call) begin
            ras_mem[ras_ptr] <= pc_inc;
            ras_ptr          <= ras_ptr + PTR_W'(1);
            pc               <= entry;
            if (ras_full) ras_overflow <= 1'b1;
            else          ras_count    <= ras_count + CNT_W'(1);
        end else if (br_abs) begin
            pc <= entry;
        end else if (rel_taken) begin
            pc <= pc + entry;
        end else begin
            pc <= pc_inc;
        end
    end

endmodule

// File: tb/tb_fetch_ctrl.sv
// tb/tb_fetch_ctrl.sv - vectors, corner sequences and randomized model check for fetch_ctrl
module tb_fetch_ctrl;

    localparam int DEPTH = 4;

    logic        CLK = 1'b0;
    logic        reset;
    logic        start, br_abs, br_rel_z, br_rel_nz, call, ret, flag_zero, halt, tbl_we;
    logic [4:0]  target_idx, tbl_waddr;
    logic [15:0] tbl_wdata;
    logic [15:0] pc;
    logic        done, ras_overflow, ras_underflow;
    logic [2:0]  ras_count;

    int total = 0;
    int bad   = 0;

    fetch_ctrl dut (
        .CLK(CLK), .reset(reset), .start(start), .br_abs(br_abs), .br_rel_z(br_rel_z),
        .br_rel_nz(br_rel_nz), .call(call), .ret(ret), .flag_zero(flag_zero),
        .target_idx(target_idx), .halt(halt), .tbl_we(tbl_we), .tbl_waddr(tbl_waddr),
        .tbl_wdata(tbl_wdata), .pc(pc), .done(done), .ras_count(ras_count),
        .ras_overflow(ras_overflow), .ras_underflow(ras_underflow)
    );

    always #5 CLK = ~CLK;

    // Reference model: plain array table, queue stack (front = oldest).
    logic [15:0] m_tbl [32];
    logic [15:0] m_stk [$];
    logic [15:0] m_pc;
    logic        m_done, m_ovf, m_unf;

    task automatic model_reset();
        for (int i = 0; i < 32; i++) m_tbl[i] = '0;
        m_stk.delete();
        m_pc = '0; m_done = 0; m_ovf = 0; m_unf = 0;
    endtask

    task automatic model_step();
        logic [15:0] e;
        e = m_tbl[target_idx];
        if (start) begin
            m_pc = '0; m_done = 0; m_ovf = 0; m_unf = 0; m_stk.delete();
        end else if (m_done) begin
        end else if (halt) begin
            m_done = 1;
        end else if (ret) begin
            if (m_stk.size() > 0) m_pc = m_stk.pop_back();
            else begin m_pc = m_pc + 16'd1; m_unf = 1; end
        end else if (call) begin
            if (m_stk.size() == DEPTH) begin void'(m_stk.pop_front()); m_ovf = 1; end
            m_stk.push_back(m_pc + 16'd1);
            m_pc = e;
        end else if (br_abs) begin
            m_pc = e;
        end else if ((br_rel_z && flag_zero) || (br_rel_nz && !flag_zero)) begin
            m_pc = m_pc + e;
        end else begin
            m_pc = m_pc + 16'd1;
        end
        if (tbl_we) m_tbl[tbl_waddr] = tbl_wdata;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h", name, act, exp);
        end
    endtask

    task automatic idle();
        start = 0; br_abs = 0; br_rel_z = 0; br_rel_nz = 0; call = 0; ret = 0;
        flag_zero = 0; halt = 0; tbl_we = 0; target_idx = '0; tbl_waddr = '0; tbl_wdata = '0;
    endtask

    task automatic step();
        @(posedge CLK);
        model_step();
        @(negedge CLK);
    endtask

    task automatic drive(input logic [6:0] ctl, input logic fz, input logic [4:0] idx,
                         input logic we, input logic [4:0] wa, input logic [15:0] wd);
        {start, halt, ret, call, br_abs, br_rel_z, br_rel_nz} = ctl;
        flag_zero = fz; target_idx = idx; tbl_we = we; tbl_waddr = wa; tbl_wdata = wd;
    endtask

    localparam logic [6:0] SEQ = 7'd0, C_START = 7'd64, C_HALT = 7'd32, C_RET = 7'd16,
                           C_CALL = 7'd8, C_ABS = 7'd4, C_RZ = 7'd2, C_RNZ = 7'd1;

    typedef struct {
        logic [6:0]  ctl;
        logic        fz;
        logic [4:0]  idx;
        logic        we;
        logic [4:0]  wa;
        logic [15:0] wd;
        logic [15:0] exp_pc;
        logic [2:0]  exp_cnt;
    } vec_t;

    vec_t vecs [23];

    initial begin
        vecs[0]  = '{SEQ,    0, 0, 1, 3, 16'h0040, 16'h0001, 0};
        vecs[1]  = '{SEQ,    0, 0, 1, 4, 16'hFFFE, 16'h0002, 0};
        vecs[2]  = '{SEQ,    0, 0, 1, 5, 16'h0010, 16'h0003, 0};
        vecs[3]  = '{SEQ,    0, 0, 1, 6, 16'h0005, 16'h0004, 0};
        vecs[4]  = '{SEQ,    0, 0, 1, 7, 16'hFFFC, 16'h0005, 0};
        vecs[5]  = '{C_ABS,  0, 5, 0, 0, 16'h0000, 16'h0010, 0};
        vecs[6]  = '{C_ABS,  0, 3, 0, 0, 16'h0000, 16'h0040, 0};
        vecs[7]  = '{C_RNZ,  0, 4, 0, 0, 16'h0000, 16'h003E, 0};
        vecs[8]  = '{C_RZ,   0, 4, 0, 0, 16'h0000, 16'h003F, 0};
        vecs[9]  = '{C_ABS,  0, 6, 0, 0, 16'h0000, 16'h0005, 0};
        vecs[10] = '{C_CALL, 0, 3, 0, 0, 16'h0000, 16'h0040, 1};
        vecs[11] = '{SEQ,    0, 0, 0, 0, 16'h0000, 16'h0041, 1};
        vecs[12] = '{SEQ,    0, 0, 0, 0, 16'h0000, 16'h0042, 1};
        vecs[13] = '{SEQ,    0, 0, 0, 0, 16'h0000, 16'h0043, 1};
        vecs[14] = '{SEQ,    0, 0, 0, 0, 16'h0000, 16'h0044, 1};
        vecs[15] = '{SEQ,    0, 0, 0, 0, 16'h0000, 16'h0045, 1};
        vecs[16] = '{C_RET,  0, 0, 0, 0, 16'h0000, 16'h0006, 0};
        vecs[17] = '{C_RZ | C_RNZ, 1, 4, 0, 0, 16'h0000, 16'h0004, 0};
        vecs[18] = '{C_RZ | C_RNZ, 0, 4, 0, 0, 16'h0000, 16'h0002, 0};
        vecs[19] = '{C_RZ,   1, 7, 0, 0, 16'h0000, 16'hFFFE, 0};
        vecs[20] = '{SEQ,    0, 0, 0, 0, 16'h0000, 16'hFFFF, 0};
        vecs[21] = '{SEQ,    0, 0, 0, 0, 16'h0000, 16'h0000, 0};
        vecs[22] = '{C_RNZ,  1, 4, 0, 0, 16'h0000, 16'h0001, 0};

        idle();
        reset = 1;
        model_reset();
        @(negedge CLK);
        reset = 0;
        check("reset_pc", 32'(pc), 0);
        check("reset_done", 32'(done), 0);
        check("reset_cnt", 32'(ras_count), 0);
        check("reset_flags", 32'({ras_overflow, ras_underflow}), 0);

        for (int i = 0; i < 23; i++) begin
            drive(vecs[i].ctl, vecs[i].fz, vecs[i].idx, vecs[i].we, vecs[i].wa, vecs[i].wd);
            step();
            check($sformatf("vec%0d_pc", i), 32'(pc), 32'(vecs[i].exp_pc));
            check($sformatf("vec%0d_cnt", i), 32'(ras_count), 32'(vecs[i].exp_cnt));
        end

        // Nested calls past depth: targets 0x100..0x500 loaded while held in start.
        for (int i = 0; i < 5; i++) begin
            drive(C_START, 0, 0, 1, 5'(8 + i), 16'((i + 1) * 256));
            step();
        end
        check("start_pc", 32'(pc), 0);
        for (int i = 0; i < 5; i++) begin
            drive(C_CALL, 0, 5'(8 + i), 0, 0, 0);
            step();
            check($sformatf("call%0d_pc", i), 32'(pc), 32'((i + 1) * 256));
        end
        check("ovf_cnt", 32'(ras_count), 4);
        check("ovf_flag", 32'(ras_overflow), 1);
        for (int i = 0; i < 4; i++) begin
            drive(C_RET, 0, 0, 0, 0, 0);
            step();
            check($sformatf("ret%0d_pc", i), 32'(pc), 32'((4 - i) * 256 + 1));
        end
        check("ret_cnt", 32'(ras_count), 0);
        check("unf_before", 32'(ras_underflow), 0);
        step();
        check("unf_pc", 32'(pc), 32'h0102);
        check("unf_flag", 32'(ras_underflow), 1);

        // Halt holds pc and done; a table write still lands.
        drive(SEQ, 0, 0, 1, 13, 16'h0020); step();
        drive(C_ABS, 0, 13, 0, 0, 0); step();
        check("pre_halt_pc", 32'(pc), 32'h0020);
        drive(C_HALT, 0, 0, 0, 0, 0); step();
        check("halt_done", 32'(done), 1);
        for (int i = 0; i < 10; i++) begin
            drive(C_ABS, 0, 3, (i == 0), 14, 16'h0077);
            step();
            check($sformatf("halt%0d_pc", i), 32'(pc), 32'h0020);
        end
        check("halt_done_hold", 32'(done), 1);
        drive(C_START, 0, 0, 0, 0, 0); step();
        check("start_pc2", 32'(pc), 0);
        check("start_done", 32'(done), 0);
        check("start_flags", 32'({ras_overflow, ras_underflow}), 0);
        drive(C_ABS, 0, 14, 0, 0, 0); step();
        check("halt_write_pc", 32'(pc), 32'h0077);

        // Same-cycle write and read of one index.
        drive(C_ABS, 0, 3, 1, 3, 16'h0080); step();
        check("rw_old_pc", 32'(pc), 32'h0040);
        drive(C_ABS, 0, 3, 0, 0, 0); step();
        check("rw_new_pc", 32'(pc), 32'h0080);

        // Async reset between edges.
        drive(C_CALL, 0, 3, 0, 0, 0); step();
        idle();
        #2;
        reset = 1;
        model_reset();
        #1;
        check("async_pc", 32'(pc), 0);
        check("async_cnt", 32'(ras_count), 0);
        check("async_done", 32'(done), 0);
        @(negedge CLK);
        reset = 0;

        // Randomized run against the model.
        for (int n = 0; n < 800; n++) begin
            int r;
            idle();
            r = $urandom_range(0, 99);
            if      (r < 3)  start = 1;
            else if (r < 6)  halt = 1;
            else if (r < 22) ret = 1;
            else if (r < 40) call = 1;
            else if (r < 52) br_abs = 1;
            else if (r < 62) br_rel_z = 1;
            else if (r < 72) br_rel_nz = 1;
            else if (r < 76) {br_rel_z, br_rel_nz} = 2'b11;
            flag_zero  = 1'($urandom);
            target_idx = 5'($urandom);
            tbl_we     = ($urandom_range(0, 3) == 0);
            tbl_waddr  = 5'($urandom);
            tbl_wdata  = 16'($urandom);
            step();
            check("rnd_pc", 32'(pc), 32'(m_pc));
            check("rnd_done", 32'(done), 32'(m_done));
            check("rnd_cnt", 32'(ras_count), 32'(m_stk.size()));
            check("rnd_ovf", 32'(ras_overflow), 32'(m_ovf));
            check("rnd_unf", 32'(ras_underflow), 32'(m_unf));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
